// File: rtl/mem_bus_arbiter_if.sv
// Port bundle of the kernel memory-bus arbiter: IF port, LS port, memory side and status.
// The arbiter connects through "slave"; the environment (ports plus memory) through "master".
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_DV;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_if_err;

  logic              i_ls_req;
  logic              i_ls_write;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [DATA_W-1:0] i_ls_wdata;
  logic [3:0]        i_ls_be;
  logic              o_ls_gnt;
  logic              o_ls_DV;
  logic [DATA_W-1:0] o_ls_rdata;
  logic              o_ls_err;

  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_address;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              o_mem_write;
  logic [3:0]        o_mem_be;
  logic              i_mem_ready;
  logic              i_mem_DV;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              o_busy;
  logic [7:0]        o_timeout_count;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_DV, o_if_rdata, o_if_err,
    input  i_ls_req, i_ls_write, i_ls_addr, i_ls_wdata, i_ls_be,
    output o_ls_gnt, o_ls_DV, o_ls_rdata, o_ls_err,
    output o_mem_req, o_mem_address, o_mem_wdata, o_mem_write, o_mem_be,
    input  i_mem_ready, i_mem_DV, i_mem_rdata,
    output o_busy, o_timeout_count
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_DV, o_if_rdata, o_if_err,
    output i_ls_req, i_ls_write, i_ls_addr, i_ls_wdata, i_ls_be,
    input  o_ls_gnt, o_ls_DV, o_ls_rdata, o_ls_err,
    input  o_mem_req, o_mem_address, o_mem_wdata, o_mem_write, o_mem_be,
    output i_mem_ready, i_mem_DV, i_mem_rdata,
    input  o_busy, o_timeout_count
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the kernel memory bus between the IF and LS ports: one transaction in flight,
// round-robin on contention, response timeout with a saturating abort counter.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  owner_t            owner;
  owner_t            last_owner;
  logic [7:0]        tmo;
  logic [7:0]        timeout_count;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [3:0]        mem_be;

  logic pick_ls;
  logic accept;
  logic respond;
  logic expire;

  // On contention the port that did not own the previous turn wins.
  always_comb begin
    pick_ls = bus.i_ls_req && (!bus.i_if_req || last_owner == OWN_IF);
    accept  = (state == ST_ISSUE) && bus.i_mem_ready;
    respond = (state == ST_WAIT) && bus.i_mem_DV;
    expire  = (state == ST_WAIT) && !bus.i_mem_DV && (tmo == TMO_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      owner         <= OWN_IF;
      last_owner    <= OWN_LS;
      tmo           <= '0;
      timeout_count <= '0;
      mem_address   <= '0;
      mem_wdata     <= '0;
      mem_write     <= 1'b0;
      mem_be        <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.i_if_req || bus.i_ls_req) begin
            if (pick_ls) begin
              owner       <= OWN_LS;
              mem_address <= bus.i_ls_addr;
              mem_wdata   <= bus.i_ls_wdata;
              mem_write   <= bus.i_ls_write;
              mem_be      <= bus.i_ls_be;
            end else begin
              owner       <= OWN_IF;
              mem_address <= bus.i_if_addr;
              mem_wdata   <= '0;
              mem_write   <= 1'b0;
              mem_be      <= '1;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            last_owner <= owner;
            tmo        <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          tmo <= tmo + 8'd1;
          if (respond) begin
            state <= ST_IDLE;
          end else if (expire) begin
            if (timeout_count != '1) timeout_count <= timeout_count + 8'd1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake pulses are combinational so grant and data land in the memory's own cycle.
  always_comb begin
    bus.o_if_gnt   = accept && (owner == OWN_IF);
    bus.o_ls_gnt   = accept && (owner == OWN_LS);
    bus.o_if_DV    = (respond || expire) && (owner == OWN_IF);
    bus.o_ls_DV    = (respond || expire) && (owner == OWN_LS);
    bus.o_if_err   = expire && (owner == OWN_IF);
    bus.o_ls_err   = expire && (owner == OWN_LS);
    bus.o_if_rdata = (respond && owner == OWN_IF) ? bus.i_mem_rdata : '0;
    bus.o_ls_rdata = (respond && owner == OWN_LS) ? bus.i_mem_rdata : '0;
  end

  assign bus.o_mem_req       = (state == ST_ISSUE);
  assign bus.o_mem_address   = mem_address;
  assign bus.o_mem_wdata     = mem_wdata;
  assign bus.o_mem_write     = mem_write;
  assign bus.o_mem_be        = mem_be;
  assign bus.o_busy          = (state != ST_IDLE);
  assign bus.o_timeout_count = timeout_count;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-plus-random bench for mem_bus_arbiter; the bench plays both ports and the memory
// and predicts each turn (winner, bus attributes, response or abort) from the arbitration rules.
module tb_mem_bus_arbiter;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: pending requests, who owned the last turn, last bus attributes.
  bit          m_if_req, m_ls_req, m_last_ls;
  int          m_tcount;
  int          n_if_gnt, n_ls_gnt;
  logic [31:0] m_if_addr, m_ls_addr, m_ls_wdata, m_prev_addr, m_prev_wdata;
  logic        m_ls_write, m_prev_write;
  logic [3:0]  m_ls_be, m_prev_be;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_if(input logic [31:0] a);
    bus.i_if_req = 1'b1; bus.i_if_addr = a;
    m_if_req = 1'b1; m_if_addr = a;
  endtask

  task automatic raise_ls(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.i_ls_req = 1'b1; bus.i_ls_write = w; bus.i_ls_addr = a; bus.i_ls_wdata = d; bus.i_ls_be = be;
    m_ls_req = 1'b1; m_ls_write = w; m_ls_addr = a; m_ls_wdata = d; m_ls_be = be;
  endtask

  task automatic chk_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_mreq"}, bus.o_mem_req, 0);
    chk({tag, "_attr"}, {bus.o_mem_address, bus.o_mem_wdata}, 0);
    chk({tag, "_wrbe"}, {bus.o_mem_write, bus.o_mem_be}, 0);
    chk({tag, "_tcnt"}, bus.o_timeout_count, 0);
    chk({tag, "_pulses"}, {bus.o_if_gnt, bus.o_ls_gnt, bus.o_if_DV, bus.o_ls_DV, bus.o_if_err, bus.o_ls_err}, 0);
    chk({tag, "_rdata"}, {bus.o_if_rdata, bus.o_ls_rdata}, 0);
  endtask

  // Idle cycle with a stray memory response that must be ignored.
  task automatic idle_cycle();
    bus.i_mem_DV = 1'b1; bus.i_mem_rdata = $urandom;
    @(negedge clk);
    chk("idle_busy", bus.o_busy, 0);
    chk("idle_stray_dv", {bus.o_if_DV, bus.o_ls_DV, bus.o_if_err, bus.o_ls_err}, 0);
    step();
    bus.i_mem_DV = 1'b0;
  endtask

  // One full turn from IDLE; dv_dly >= TMO means memory never answers.
  task automatic do_turn(input int rdy_dly, input int dv_dly, input logic [31:0] rd);
    bit          win_ls, to, done;
    logic [31:0] ea, ed;
    logic        ew;
    logic [3:0]  eb;
    if (m_if_req && m_ls_req) win_ls = !m_last_ls;
    else                      win_ls = m_ls_req;
    if (win_ls) begin ea = m_ls_addr; ed = m_ls_wdata; ew = m_ls_write; eb = m_ls_be; end
    else        begin ea = m_if_addr; ed = 32'h0;      ew = 1'b0;       eb = 4'hF;     end
    to = (dv_dly >= TMO);

    @(negedge clk);
    chk("idle_busy", bus.o_busy, 0);
    chk("idle_mreq", bus.o_mem_req, 0);
    chk("idle_pulses", {bus.o_if_gnt, bus.o_ls_gnt, bus.o_if_DV, bus.o_ls_DV}, 0);
    chk("hold_addr", bus.o_mem_address, m_prev_addr);
    chk("hold_wdata", bus.o_mem_wdata, m_prev_wdata);
    chk("hold_wrbe", {bus.o_mem_write, bus.o_mem_be}, {m_prev_write, m_prev_be});
    chk("tmo_count", bus.o_timeout_count, m_tcount);
    step();

    for (int i = 0; i <= rdy_dly; i++) begin
      bus.i_mem_ready = (i == rdy_dly);
      bus.i_mem_DV    = 1'($urandom_range(0, 1));
      bus.i_mem_rdata = $urandom;
      @(negedge clk);
      chk("iss_mreq", bus.o_mem_req, 1);
      chk("iss_busy", bus.o_busy, 1);
      chk("iss_addr", bus.o_mem_address, ea);
      chk("iss_wdata", bus.o_mem_wdata, ed);
      chk("iss_wrbe", {bus.o_mem_write, bus.o_mem_be}, {ew, eb});
      chk("iss_gnt", {bus.o_if_gnt, bus.o_ls_gnt},
          (i == rdy_dly) ? (win_ls ? 2'b01 : 2'b10) : 2'b00);
      chk("iss_dv", {bus.o_if_DV, bus.o_ls_DV, bus.o_if_err, bus.o_ls_err}, 0);
      if (bus.o_if_gnt === 1'b1) n_if_gnt++;
      if (bus.o_ls_gnt === 1'b1) n_ls_gnt++;
      step();
    end
    bus.i_mem_ready = 1'b0;
    bus.i_mem_DV    = 1'b0;
    if (win_ls) begin bus.i_ls_req = 1'b0; m_ls_req = 1'b0; end
    else        begin bus.i_if_req = 1'b0; m_if_req = 1'b0; end
    m_last_ls = win_ls;
    m_prev_addr = ea; m_prev_wdata = ed; m_prev_write = ew; m_prev_be = eb;

    for (int k = 0; k < TMO; k++) begin
      done = (k == dv_dly) || (k == TMO - 1);
      bus.i_mem_DV    = (k == dv_dly);
      bus.i_mem_rdata = rd;
      @(negedge clk);
      chk("wait_busy", bus.o_busy, 1);
      chk("wait_mreq", bus.o_mem_req, 0);
      chk("wait_gnt", {bus.o_if_gnt, bus.o_ls_gnt}, 0);
      chk("wait_dv", {bus.o_if_DV, bus.o_ls_DV}, done ? (win_ls ? 2'b01 : 2'b10) : 2'b00);
      chk("wait_err", {bus.o_if_err, bus.o_ls_err},
          (done && to) ? (win_ls ? 2'b01 : 2'b10) : 2'b00);
      if (done) chk("wait_rdata", win_ls ? bus.o_ls_rdata : bus.o_if_rdata, to ? 32'h0 : rd);
      step();
      if (done) break;
    end
    bus.i_mem_DV = 1'b0;
    if (to && m_tcount < 255) m_tcount++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.i_if_req = 0; bus.i_if_addr = '0;
    bus.i_ls_req = 0; bus.i_ls_write = 0; bus.i_ls_addr = '0; bus.i_ls_wdata = '0; bus.i_ls_be = '0;
    bus.i_mem_ready = 0; bus.i_mem_DV = 0; bus.i_mem_rdata = '0;
    m_if_req = 0; m_ls_req = 0; m_last_ls = 1; m_tcount = 0;
    m_prev_addr = '0; m_prev_wdata = '0; m_prev_write = 0; m_prev_be = '0;
    n_if_gnt = 0; n_ls_gnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_all_zero("reset");
    step();

    // IF fetch with a two-cycle memory response
    raise_if(32'h8000_0000);
    do_turn(0, 1, 32'h0000_0297);

    // LS partial write
    raise_ls(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3);
    do_turn(0, 0, $urandom);

    // LS read that times out, then stray responses while idle
    raise_ls(1'b0, 32'h8000_2000, 32'h0, 4'hF);
    do_turn(1, TMO, $urandom);
    repeat (3) idle_cycle();

    // Both ports requesting continuously must alternate
    n_if_gnt = 0; n_ls_gnt = 0;
    for (int t = 0; t < 100; t++) begin
      if (!m_if_req) raise_if($urandom & 32'hFFFF_FFFC);
      if (!m_ls_req) raise_ls(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      do_turn(0, 0, $urandom);
    end
    chk("fair_if", n_if_gnt, 50);
    chk("fair_ls", n_ls_gnt, 50);
    do_turn(0, 0, $urandom);

    // Reset pulse while an LS read is waiting for memory
    raise_ls(1'b0, 32'h8000_3000, 32'h0, 4'hF);
    @(negedge clk);
    step();
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_pre_gnt", bus.o_ls_gnt, 1);
    step();
    bus.i_mem_ready = 1'b0; bus.i_ls_req = 1'b0; m_ls_req = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_wait_dv", {bus.o_if_DV, bus.o_ls_DV}, 0);
    step();
    reset_n = 1'b1;
    m_last_ls = 1; m_tcount = 0;
    m_prev_addr = '0; m_prev_wdata = '0; m_prev_write = 0; m_prev_be = '0;
    chk_all_zero("rst_mid");
    step();
    raise_if(32'h8000_4000);
    raise_ls(1'b1, 32'h8000_5000, 32'h1234_5678, 4'hC);
    do_turn(0, 0, $urandom);
    do_turn(0, 2, $urandom);

    // Random traffic, random memory latency including aborts
    for (int t = 0; t < 200; t++) begin
      if (!m_if_req && !m_ls_req && $urandom_range(0, 3) == 0) idle_cycle();
      if (!m_if_req && $urandom_range(0, 1) == 1) raise_if($urandom);
      if (!m_ls_req && $urandom_range(0, 1) == 1)
        raise_ls(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!m_if_req && !m_ls_req) raise_if($urandom);
      do_turn($urandom_range(0, 2), $urandom_range(0, TMO + 1), $urandom);
    end
    repeat (2) if (m_if_req || m_ls_req) do_turn(0, 0, $urandom);

    // Abort counter saturation
    for (int t = 0; t < 300; t++) begin
      raise_if($urandom);
      do_turn(0, TMO, $urandom);
    end
    @(negedge clk);
    chk("tmo_saturated", bus.o_timeout_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
